axi_lite_slave_mem: RTL and testbench

//  Parametrised AXI4-Lite slave memory; full write (AW/W/B) and read (AR/R) channels.

---
 rtl/axi_lite_slave_mem.sv | 211 +++++++++++++++++++++
 tb/tb_axi_lite_slave_mem.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave backed by a DEPTH-word register file with per-byte strobes.
// Write and read paths are independent FSMs; out-of-range word indices answer SLVERR.
module axi_lite_slave_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int IDX_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_LIMIT = ADDR_WIDTH'(DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state_reg, w_state_next;
  r_state_t r_state_reg, r_state_next;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  logic [ADDR_WIDTH-1:0] aw_addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [STRB_WIDTH-1:0] wstrb_reg;
  logic [1:0]            bresp_reg;
  logic [1:0]            rresp_reg;

  logic [ADDR_WIDTH-1:0] commit_addr;
  logic [DATA_WIDTH-1:0] commit_data;
  logic [STRB_WIDTH-1:0] commit_strb;
  logic                  commit;
  logic                  commit_in_range;
  logic [IDX_WIDTH-1:0]  commit_idx;
  logic                  ar_in_range;
  logic [IDX_WIDTH-1:0]  ar_idx;

  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID & WREADY;
  assign b_hs  = BVALID & BREADY;
  assign ar_hs = ARVALID & ARREADY;
  assign r_hs  = RVALID & RREADY;

  // Write FSM: state register
  always_ff @(posedge ACLK) begin
    if (!ARESET) begin
      w_state_reg <= W_IDLE;
    end else begin
      w_state_reg <= w_state_next;
    end
  end

  // Write FSM: next state
  always_comb begin
    w_state_next = w_state_reg;
    case (w_state_reg)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          w_state_next = W_RESP;
        end else if (aw_hs) begin
          w_state_next = W_HAVE_A;
        end else if (w_hs) begin
          w_state_next = W_HAVE_D;
        end
      end
      W_HAVE_A: if (w_hs)  w_state_next = W_RESP;
      W_HAVE_D: if (aw_hs) w_state_next = W_RESP;
      W_RESP:   if (b_hs)  w_state_next = W_IDLE;
      default:  w_state_next = W_IDLE;
    endcase
  end

  // Write FSM: outputs; readies are held low while reset is asserted
  always_comb begin
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    case (w_state_reg)
      W_IDLE: begin
        AWREADY = ARESET;
        WREADY  = ARESET;
      end
      W_HAVE_A: WREADY  = ARESET;
      W_HAVE_D: AWREADY = ARESET;
      W_RESP:   BVALID  = 1'b1;
      default: begin
        AWREADY = 1'b0;
        WREADY  = 1'b0;
      end
    endcase
  end

  assign BRESP = bresp_reg;

  // Address and data are captured at their own handshakes.
  always_ff @(posedge ACLK) begin
    if (aw_hs) begin
      aw_addr_reg <= AWADDR;
    end
    if (w_hs) begin
      wdata_reg <= WDATA;
      wstrb_reg <= WSTRB;
    end
  end

  // On the completing edge the second half arrives straight from the bus.
  assign commit_addr     = aw_hs ? AWADDR : aw_addr_reg;
  assign commit_data     = w_hs  ? WDATA  : wdata_reg;
  assign commit_strb     = w_hs  ? WSTRB  : wstrb_reg;
  assign commit          = ARESET && (w_state_next == W_RESP) && (w_state_reg != W_RESP);
  assign commit_in_range = (commit_addr >> ADDR_LSB) < DEPTH_LIMIT;
  assign commit_idx      = IDX_WIDTH'(commit_addr >> ADDR_LSB);

  always_ff @(posedge ACLK) begin
    if (!ARESET) begin
      bresp_reg <= RESP_OKAY;
    end else if (commit) begin
      bresp_reg <= commit_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Read FSM: state register
  always_ff @(posedge ACLK) begin
    if (!ARESET) begin
      r_state_reg <= R_IDLE;
    end else begin
      r_state_reg <= r_state_next;
    end
  end

  // Read FSM: next state
  always_comb begin
    r_state_next = r_state_reg;
    case (r_state_reg)
      R_IDLE:  if (ar_hs) r_state_next = R_DATA;
      R_DATA:  if (r_hs)  r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  // Read FSM: outputs
  always_comb begin
    ARREADY = 1'b0;
    RVALID  = 1'b0;
    case (r_state_reg)
      R_IDLE:  ARREADY = ARESET;
      R_DATA:  RVALID  = 1'b1;
      default: ARREADY = 1'b0;
    endcase
  end

  assign ar_in_range = (ARADDR >> ADDR_LSB) < DEPTH_LIMIT;
  assign ar_idx      = IDX_WIDTH'(ARADDR >> ADDR_LSB);

  always_ff @(posedge ACLK) begin
    if (!ARESET) begin
      rresp_reg <= RESP_OKAY;
    end else if (ar_hs) begin
      rresp_reg <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign RRESP = rresp_reg;

  // One byte-wide RAM per lane; a read on the commit edge sees the old contents.
  genvar gi;
  generate
    for (gi = 0; gi < STRB_WIDTH; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] rdata_lane_reg;

      always_ff @(posedge ACLK) begin
        if (commit && commit_in_range && commit_strb[gi]) begin
          lane_mem[commit_idx] <= commit_data[gi*8 +: 8];
        end
      end

      always_ff @(posedge ACLK) begin
        if (!ARESET) begin
          rdata_lane_reg <= 8'h00;
        end else if (ar_hs) begin
          rdata_lane_reg <= ar_in_range ? lane_mem[ar_idx] : 8'h00;
        end
      end

      assign RDATA[gi*8 +: 8] = rdata_lane_reg;
    end
  endgenerate

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Bench for axi_lite_slave_mem (32-bit data, 16 words): scoreboard queues of
// expected B and R responses, filled from a reference word array as stimulus is issued.
module tb_axi_lite_slave_mem;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [16];
  logic [1:0]  bexp_q [$];
  logic [33:0] rexp_q [$];

  axi_lite_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  task automatic wait_b(input int hold);
    int t;
    logic [1:0] held;
    logic [1:0] exp_resp;
    t = 0;
    while (BVALID !== 1'b1 && t < 20) begin
      @(negedge ACLK);
      t++;
    end
    checks++;
    if (BVALID !== 1'b1) begin
      errors++;
      $display("FAIL b_timeout: BVALID=%b required 1", BVALID);
      return;
    end
    held = BRESP;
    for (int k = 0; k < hold; k++) begin
      BREADY = 1'b0;
      @(negedge ACLK);
      checks++;
      if (BVALID !== 1'b1 || BRESP !== held || AWREADY !== 1'b0 || WREADY !== 1'b0) begin
        errors++;
        $display("FAIL b_stall: BVALID=%b BRESP=%b AWREADY=%b WREADY=%b required 1 %b 0 0",
                 BVALID, BRESP, AWREADY, WREADY, held);
      end
    end
    exp_resp = (bexp_q.size() > 0) ? bexp_q.pop_front() : 2'bxx;
    checks++;
    if (BRESP !== exp_resp) begin
      errors++;
      $display("FAIL bresp: got %b required %b", BRESP, exp_resp);
    end
    $display("B   handshake resp=%b", BRESP);
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    checks++;
    if (BVALID !== 1'b0) begin
      errors++;
      $display("FAIL b_release: BVALID=%b required 0", BVALID);
    end
  endtask

  task automatic wait_r(input int hold);
    int t;
    logic [33:0] held;
    logic [33:0] exp_r;
    t = 0;
    while (RVALID !== 1'b1 && t < 20) begin
      @(negedge ACLK);
      t++;
    end
    checks++;
    if (RVALID !== 1'b1) begin
      errors++;
      $display("FAIL r_timeout: RVALID=%b required 1", RVALID);
      return;
    end
    held = {RRESP, RDATA};
    for (int k = 0; k < hold; k++) begin
      RREADY = 1'b0;
      @(negedge ACLK);
      checks++;
      if (RVALID !== 1'b1 || {RRESP, RDATA} !== held || ARREADY !== 1'b0) begin
        errors++;
        $display("FAIL r_stall: RVALID=%b RRESP/RDATA=%h ARREADY=%b required 1 %h 0",
                 RVALID, {RRESP, RDATA}, ARREADY, held);
      end
    end
    exp_r = (rexp_q.size() > 0) ? rexp_q.pop_front() : 34'bx;
    checks++;
    if (RDATA !== exp_r[31:0] || RRESP !== exp_r[33:32]) begin
      errors++;
      $display("FAIL rdata: got data=%h resp=%b required data=%h resp=%b",
               RDATA, RRESP, exp_r[31:0], exp_r[33:32]);
    end
    $display("R   handshake data=%h resp=%b", RDATA, RRESP);
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
    checks++;
    if (RVALID !== 1'b0) begin
      errors++;
      $display("FAIL r_release: RVALID=%b required 0", RVALID);
    end
  endtask

  // Pushes the expected response, updates the reference array, then runs AW/W/B.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_hold);
    logic [31:0] widx;
    logic aw_done, w_done;
    int cyc;
    widx = addr >> 2;
    if (widx < 32'd16) begin
      bexp_q.push_back(2'b00);
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model_mem[widx[3:0]][b*8 +: 8] = data[b*8 +: 8];
      end
    end else begin
      bexp_q.push_back(2'b10);
    end
    aw_done = 1'b0;
    w_done  = 1'b0;
    cyc = 0;
    while (!(aw_done && w_done)) begin
      @(negedge ACLK);
      if (cyc > 40) begin
        errors++;
        $display("FAIL write_accept_timeout: aw_done=%b w_done=%b required 1 1", aw_done, w_done);
        break;
      end
      AWVALID = !aw_done && (cyc >= aw_dly);
      AWADDR  = addr;
      WVALID  = !w_done && (cyc >= w_dly);
      WDATA   = data;
      WSTRB   = strb;
      checks++;
      if (BVALID !== 1'b0) begin
        errors++;
        $display("FAIL b_early: BVALID=%b required 0 before both handshakes", BVALID);
      end
      if (AWVALID && AWREADY) aw_done = 1'b1;
      if (WVALID && WREADY) w_done = 1'b1;
      cyc++;
    end
    @(negedge ACLK);
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    checks++;
    if (BVALID !== 1'b1) begin
      errors++;
      $display("FAIL b_latency: BVALID=%b one cycle after last handshake, required 1", BVALID);
    end
    wait_b(b_hold);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int ar_dly, input int r_hold);
    logic [31:0] widx;
    logic done;
    int cyc;
    widx = addr >> 2;
    if (widx < 32'd16) rexp_q.push_back({2'b00, model_mem[widx[3:0]]});
    else               rexp_q.push_back({2'b10, 32'h0});
    done = 1'b0;
    cyc = 0;
    while (!done) begin
      @(negedge ACLK);
      if (cyc > 40) begin
        errors++;
        $display("FAIL ar_timeout: ARREADY=%b required 1", ARREADY);
        break;
      end
      ARVALID = (cyc >= ar_dly);
      ARADDR  = addr;
      if (ARVALID && ARREADY) done = 1'b1;
      cyc++;
    end
    @(negedge ACLK);
    ARVALID = 1'b0;
    checks++;
    if (RVALID !== 1'b1) begin
      errors++;
      $display("FAIL r_latency: RVALID=%b one cycle after AR handshake, required 1", RVALID);
    end
    wait_r(r_hold);
  endtask

  task automatic test_reset();
    ARESET = 1'b0;
    AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0; ARVALID = 1'b0; RREADY = 1'b0;
    AWADDR = '0; WDATA = '0; WSTRB = '0; ARADDR = '0;
    repeat (3) @(negedge ACLK);
    checks++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0 || BRESP !== 2'b00 ||
        RRESP !== 2'b00 || RDATA !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: rdy/valid=%b BRESP=%b RRESP=%b RDATA=%h required 00000 00 00 0",
               {AWREADY, WREADY, ARREADY, BVALID, RVALID}, BRESP, RRESP, RDATA);
    end
    ARESET = 1'b1;
    @(negedge ACLK);
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      errors++;
      $display("FAIL reset_release: readies=%b required 111", {AWREADY, WREADY, ARREADY});
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) axi_write(32'(i * 4), 32'hC0DE_0000 + 32'(i * 32'h111), 4'hF, 0, 0, 0);
  endtask

  task automatic test_strobe_merge();
    axi_write(32'h0, 32'hFFFF_FFFF, 4'b1111, 0, 0, 0);
    axi_write(32'h0, 32'h1234_5678, 4'b0001, 0, 0, 0);
    axi_read(32'h0, 0, 0);
    axi_write(32'h4, 32'hA5A5_A5A5, 4'b0000, 0, 0, 0);
    axi_write(32'h4, 32'h1122_3344, 4'b0110, 0, 0, 0);
    axi_read(32'h4, 0, 1);
  endtask

  task automatic test_channel_order();
    axi_write(32'h4, 32'hDEAD_BEEF, 4'hF, 3, 0, 0);
    axi_read(32'h4, 0, 0);
    axi_write(32'h17, 32'h0BB0_C00C, 4'hF, 0, 2, 0);
    axi_read(32'h14, 2, 0);
  endtask

  task automatic test_bready_stall();
    axi_write(32'h20, 32'h5A5A_0F0F, 4'hF, 0, 0, 5);
    checks++;
    if (AWREADY !== 1'b1 || WREADY !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_b: AWREADY=%b WREADY=%b required 1 1", AWREADY, WREADY);
    end
    axi_write(32'h24, 32'h0102_0304, 4'hF, 0, 0, 0);
  endtask

  task automatic test_out_of_range();
    axi_write(32'h40, 32'hFFFF_0000, 4'hF, 0, 0, 0);
    axi_write(32'hFFFF_FFFC, 32'h0000_FFFF, 4'hF, 1, 0, 0);
    for (int i = 0; i < 16; i++) axi_read(32'(i * 4), 0, 0);
    axi_read(32'h40, 0, 2);
  endtask

  task automatic test_collision();
    axi_write(32'h8, 32'hAAAA_AAAA, 4'hF, 0, 0, 0);
    rexp_q.push_back({2'b00, model_mem[2]});
    bexp_q.push_back(2'b00);
    model_mem[2] = 32'h5555_5555;
    @(negedge ACLK);
    AWVALID = 1'b1; AWADDR = 32'h8; WVALID = 1'b1; WDATA = 32'h5555_5555; WSTRB = 4'hF;
    ARVALID = 1'b1; ARADDR = 32'h8;
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      errors++;
      $display("FAIL collision_ready: readies=%b required 111", {AWREADY, WREADY, ARREADY});
    end
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    wait_r(0);
    wait_b(0);
    axi_read(32'h8, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] addr;
    for (int n = 0; n < 12; n++) begin
      addr = 32'(($urandom_range(0, 17) << 2) | $urandom_range(0, 3));
      axi_write(addr, 32'($urandom), 4'($urandom_range(0, 15)),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      addr = 32'(($urandom_range(0, 17) << 2) | $urandom_range(0, 3));
      axi_read(addr, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_reset_mid();
    @(negedge ACLK);
    AWVALID = 1'b1; AWADDR = 32'h8; WVALID = 1'b1; WDATA = 32'h0BAD_F00D; WSTRB = 4'hF;
    ARVALID = 1'b1; ARADDR = 32'h4;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    model_mem[2] = 32'h0BAD_F00D;
    checks++;
    if (BVALID !== 1'b1 || RVALID !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_valids: BVALID=%b RVALID=%b required 1 1", BVALID, RVALID);
    end
    ARESET = 1'b0;
    #1;
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin
      errors++;
      $display("FAIL ready_in_reset: readies=%b required 000", {AWREADY, WREADY, ARREADY});
    end
    @(negedge ACLK);
    checks++;
    if (BVALID !== 1'b0 || RVALID !== 1'b0 || BRESP !== 2'b00 || RRESP !== 2'b00 ||
        RDATA !== 32'h0 || {AWREADY, WREADY, ARREADY} !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset_state: BVALID=%b RVALID=%b BRESP=%b RRESP=%b RDATA=%h readies=%b required 0 0 00 00 0 000",
               BVALID, RVALID, BRESP, RRESP, RDATA, {AWREADY, WREADY, ARREADY});
    end
    ARESET = 1'b1;
    axi_read(32'h8, 0, 0);
    axi_read(32'h4, 0, 0);
    axi_read(32'h0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_strobe_merge();
    test_channel_order();
    test_bready_stall();
    test_out_of_range();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
